playfield_board: RTL and testbench

PLAYFIELD_BOARD -- requirements
Module: playfield_board

---
 rtl/tetris_pkg.sv | 14 +
 rtl/playfield_board_if.sv | 31 +++
 rtl/playfield_board_row_full_detect.sv | 11 +
 rtl/playfield_board.sv | 111 +++++++++++
 tb/tb_playfield_board.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: playfield geometry and the line-clear FSM states.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } clr_state_e;

endpackage

// File: rtl/playfield_board_if.sv
// Game-logic / display / line-clear signal bundle of the playfield board.
interface playfield_board_if;

    logic [3:0] board_rx;
    logic [4:0] board_ry;
    logic       board_rdata;
    logic       board_we;
    logic [3:0] board_wx;
    logic [4:0] board_wy;
    logic       board_wdata;
    logic [3:0] vga_x;
    logic [4:0] vga_y;
    logic       vga_rdata;
    logic       clear_req;
    logic       clear_busy;
    logic       clear_done;
    logic [4:0] lines_cleared;

    modport master (
        output board_rx, board_ry, board_we, board_wx, board_wy, board_wdata,
        output vga_x, vga_y, clear_req,
        input  board_rdata, vga_rdata, clear_busy, clear_done, lines_cleared
    );

    modport slave (
        input  board_rx, board_ry, board_we, board_wx, board_wy, board_wdata,
        input  vga_x, vga_y, clear_req,
        output board_rdata, vga_rdata, clear_busy, clear_done, lines_cleared
    );

endinterface

// File: rtl/playfield_board_row_full_detect.sv
// Flags a playfield row whose cells are all occupied.
module row_full_detect #(
    parameter int W = 10
) (
    input  logic [W-1:0] row_i,
    output logic         full_o
);

    assign full_o = &row_i;

endmodule

// File: rtl/playfield_board.sv
// Tetris playfield: row-register storage, two combinational read ports, one
// write port and a bottom-up line-clear engine that collapses full rows.
module playfield_board #(
    parameter int BOARD_W = tetris_pkg::BOARD_W,
    parameter int BOARD_H = tetris_pkg::BOARD_H
) (
    input logic              CLOCK_50,
    input logic              reset,
    playfield_board_if.slave pf
);

    import tetris_pkg::*;

    localparam logic [3:0] W_LIM = 4'(BOARD_W);
    localparam logic [4:0] H_LIM = 5'(BOARD_H);
    localparam logic [4:0] H_TOP = 5'(BOARD_H - 1);

    logic [BOARD_W-1:0] rows_q [BOARD_H];
    clr_state_e         state_q;
    logic [4:0]         scan_ptr_q;
    logic [4:0]         shift_ptr_q;
    logic [4:0]         count_q;
    logic [4:0]         lines_q;
    logic               busy_q;
    logic               done_q;
    logic               scan_full;
    logic               wr_en_d;

    row_full_detect #(.W(BOARD_W)) u_full (
        .row_i  (rows_q[scan_ptr_q]),
        .full_o (scan_full)
    );

    // Anything outside the grid reads as wall so collision checks need no bounds logic.
    always_comb begin
        pf.board_rdata = 1'b1;
        pf.vga_rdata   = 1'b1;
        if (pf.board_rx < W_LIM && pf.board_ry < H_LIM)
            pf.board_rdata = rows_q[pf.board_ry][pf.board_rx];
        if (pf.vga_x < W_LIM && pf.vga_y < H_LIM)
            pf.vga_rdata = rows_q[pf.vga_y][pf.vga_x];
    end

    always_comb begin
        wr_en_d = pf.board_we && !busy_q && (pf.board_wx < W_LIM) && (pf.board_wy < H_LIM);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rows_q      <= '{default: '0};
            state_q     <= IDLE;
            scan_ptr_q  <= '0;
            shift_ptr_q <= '0;
            count_q     <= '0;
            lines_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Writes only happen when idle, so they never collide with a shift.
            if (wr_en_d)
                rows_q[pf.board_wy][pf.board_wx] <= pf.board_wdata;
            case (state_q)
                IDLE: begin
                    if (pf.clear_req) begin
                        state_q    <= SCAN;
                        scan_ptr_q <= H_TOP;
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                SCAN: begin
                    if (scan_full) begin
                        state_q     <= SHIFT;
                        shift_ptr_q <= scan_ptr_q;
                    end else if (scan_ptr_q == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        lines_q <= count_q;
                    end else begin
                        scan_ptr_q <= scan_ptr_q - 5'd1;
                    end
                end
                SHIFT: begin
                    if (shift_ptr_q != '0) begin
                        rows_q[shift_ptr_q] <= rows_q[shift_ptr_q - 5'd1];
                        shift_ptr_q         <= shift_ptr_q - 5'd1;
                    end else begin
                        rows_q[0] <= '0;
                        if (count_q != H_LIM)
                            count_q <= count_q + 5'd1;
                        state_q <= SCAN;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pf.clear_busy    = busy_q;
    assign pf.clear_done    = done_q;
    assign pf.lines_cleared = lines_q;

endmodule

// File: tb/tb_playfield_board.sv
// Randomised self-checking bench for playfield_board against a row-list model.
module tb_playfield_board;

    localparam int W = 10;
    localparam int H = 20;

    typedef logic [W-1:0] row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    playfield_board_if pf_if();

    playfield_board #(.BOARD_W(W), .BOARD_H(H)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .pf       (pf_if)
    );

    int   total = 0;
    int   bad   = 0;
    row_t model [H];

    task automatic idle_inputs();
        pf_if.board_we    = 1'b0;
        pf_if.board_wx    = '0;
        pf_if.board_wy    = '0;
        pf_if.board_wdata = 1'b0;
        pf_if.clear_req   = 1'b0;
        pf_if.board_rx    = '0;
        pf_if.board_ry    = '0;
        pf_if.vga_x       = '0;
        pf_if.vga_y       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < H; r++) model[r] = '0;
    endtask

    task automatic model_write(input int x, input int y, input logic d);
        if (x < W && y < H) model[y][x] = d;
    endtask

    // Full rows vanish and the remaining rows settle to the bottom in order. The
    // k-th row removed (from the floor up) is found at its original index + k.
    task automatic model_clear(output int cnt, output int lat);
        row_t kept[$];
        cnt = 0;
        lat = 21;
        for (int r = H - 1; r >= 0; r--) begin
            if (model[r] == '1) begin
                lat += r + cnt + 2;
                cnt++;
            end else begin
                kept.push_back(model[r]);
            end
        end
        for (int r = H - 1; r >= 0; r--)
            model[r] = (kept.size() > 0) ? kept.pop_front() : row_t'(0);
    endtask

    task automatic read_cell(input int x, input int y, output logic b, output logic v);
        pf_if.board_rx = x[3:0];
        pf_if.board_ry = y[4:0];
        pf_if.vga_x    = x[3:0];
        pf_if.vga_y    = y[4:0];
        #1;
        b = pf_if.board_rdata;
        v = pf_if.vga_rdata;
    endtask

    task automatic check_board(input string tag);
        logic b, v;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                read_cell(x, y, b, v);
                total++;
                if (b !== model[y][x] || v !== model[y][x]) begin
                    bad++;
                    $display("FAIL %s cell(%0d,%0d): board=%b vga=%b want %b", tag, x, y, b, v, model[y][x]);
                end
            end
        end
    endtask

    task automatic write_cell(input int x, input int y, input logic d);
        @(negedge clk);
        pf_if.board_we    = 1'b1;
        pf_if.board_wx    = x[3:0];
        pf_if.board_wy    = y[4:0];
        pf_if.board_wdata = d;
        model_write(x, y, d);
        @(negedge clk);
        pf_if.board_we = 1'b0;
    endtask

    task automatic fill_row(input int y);
        for (int x = 0; x < W; x++) write_cell(x, y, 1'b1);
    endtask

    // Pulses clear_req (optionally with a same-cycle write) and times the pass.
    task automatic run_clear(input string tag, input bit inject, input bit co_write,
                             input int cx, input int cy);
        int exp_cnt, exp_lat, done_cyc, dones, busy_cnt;
        @(negedge clk);
        if (co_write) begin
            pf_if.board_we    = 1'b1;
            pf_if.board_wx    = cx[3:0];
            pf_if.board_wy    = cy[4:0];
            pf_if.board_wdata = 1'b1;
            model_write(cx, cy, 1'b1);
        end
        model_clear(exp_cnt, exp_lat);
        pf_if.clear_req = 1'b1;
        @(posedge clk);
        done_cyc = -1;
        dones    = 0;
        busy_cnt = 0;
        for (int cyc = 1; cyc <= exp_lat + 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                pf_if.clear_req = 1'b0;
                pf_if.board_we  = 1'b0;
            end
            if (inject && cyc == 3) begin
                pf_if.board_we    = 1'b1;
                pf_if.board_wx    = '0;
                pf_if.board_wy    = '0;
                pf_if.board_wdata = 1'b1;
                pf_if.clear_req   = 1'b1;
            end
            if (inject && cyc == 4) begin
                pf_if.board_we  = 1'b0;
                pf_if.clear_req = 1'b0;
            end
            if (pf_if.clear_busy === 1'b1) busy_cnt++;
            if (pf_if.clear_done === 1'b1) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        total++;
        if (done_cyc != exp_lat) begin
            bad++;
            $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cyc, exp_lat);
        end
        total++;
        if (busy_cnt != exp_lat - 1) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, exp_lat - 1);
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL %s done_pulses: got %0d want 1", tag, dones);
        end
        total++;
        if (pf_if.lines_cleared !== 5'(exp_cnt)) begin
            bad++;
            $display("FAIL %s lines_cleared: got %0d want %0d", tag, pf_if.lines_cleared, exp_cnt);
        end
        check_board({tag, "_board"});
    endtask

    task automatic test_reset();
        int   wx [3] = '{10, 0, 15};
        int   wy [3] = '{0, 20, 31};
        logic b, v;
        do_reset();
        total++;
        if (pf_if.clear_busy !== 1'b0 || pf_if.clear_done !== 1'b0 || pf_if.lines_cleared !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b lines=%0d want 0 0 0",
                     pf_if.clear_busy, pf_if.clear_done, pf_if.lines_cleared);
        end
        check_board("reset");
        for (int i = 0; i < 3; i++) begin
            read_cell(wx[i], wy[i], b, v);
            total++;
            if (b !== 1'b1 || v !== 1'b1) begin
                bad++;
                $display("FAIL wall(%0d,%0d): board=%b vga=%b want 1", wx[i], wy[i], b, v);
            end
        end
    endtask

    task automatic test_write();
        logic b, v;
        write_cell(3, 5, 1'b1);
        read_cell(3, 5, b, v);
        total++;
        if (b !== 1'b1 || v !== 1'b1) begin
            bad++;
            $display("FAIL write_one: board=%b vga=%b want 1", b, v);
        end
        write_cell(3, 5, 1'b0);
        read_cell(3, 5, b, v);
        total++;
        if (b !== 1'b0 || v !== 1'b0) begin
            bad++;
            $display("FAIL write_zero: board=%b vga=%b want 0", b, v);
        end
        write_cell(10, 3, 1'b1);
        write_cell(3, 20, 1'b1);
        write_cell(15, 31, 1'b1);
        check_board("oob_write");
    endtask

    task automatic test_clear_fixed();
        do_reset();
        run_clear("empty", 1'b0, 1'b0, 0, 0);
        do_reset();
        fill_row(19);
        write_cell(2, 18, 1'b1);
        run_clear("one_line", 1'b0, 1'b0, 0, 0);
        do_reset();
        for (int y = 16; y < 20; y++) fill_row(y);
        write_cell(0, 15, 1'b1);
        run_clear("four_lines", 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        row_t r;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int y = 6; y < H; y++) begin
                case ($urandom_range(0, 3))
                    0:       r = '0;
                    1, 2:    r = '1;
                    default: r = row_t'($urandom);
                endcase
                for (int x = 0; x < W; x++)
                    if (r[x]) write_cell(x, y, 1'b1);
            end
            run_clear("random", 1'b0, 1'b0, 0, 0);
            run_clear("random_again", 1'b0, 1'b0, 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int x = 0; x < W - 1; x++) write_cell(x, 19, 1'b1);
        write_cell(4, 17, 1'b1);
        run_clear("write_with_req", 1'b0, 1'b1, 9, 19);
    endtask

    task automatic test_busy_ignore();
        do_reset();
        fill_row(19);
        write_cell(5, 18, 1'b1);
        run_clear("busy_ignore", 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int dones;
        do_reset();
        fill_row(19);
        write_cell(1, 18, 1'b1);
        @(negedge clk);
        pf_if.clear_req = 1'b1;
        @(negedge clk);
        pf_if.clear_req = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int r = 0; r < H; r++) model[r] = '0;
        total++;
        if (pf_if.clear_busy !== 1'b0 || pf_if.clear_done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: busy=%b done=%b want 0 0", pf_if.clear_busy, pf_if.clear_done);
        end
        check_board("midreset");
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (pf_if.clear_done === 1'b1 || pf_if.clear_busy === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL midreset_no_done: got %0d active cycles want 0", dones);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write();
        test_clear_fixed();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
